// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_bank
// SPI-slave register front end for the PWM block (5 x 8-bit config registers).
// Optional macro SPI_READBACK_EN adds CIPO readback of the addressed register.
// Revision: 1.0
// ============================================================================
module spi_reg_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SCLK,
    input  logic       COPI,
    input  logic       nCS,
    output logic [7:0] data0,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [7:0] data3,
    output logic [7:0] data4,
    output logic       CIPO
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] MAX_ADDR_W = MAX_ADDR[6:0];
    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [4:0] CNT_SAT    = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   sclk_hist;
    logic                   ncs_hist;

    // Synchronizers and edge-history flops reset to the bus idle levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            ncs_hist  <= ncs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic copi_s;
    logic ncs_s;
    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;
    logic bit_in;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign ncs_fall  = ~ncs_s & ncs_hist;
    assign ncs_rise  = ncs_s & ~ncs_hist;
    assign bit_in    = sclk_rise & ~ncs_s;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        start_pend;
    logic [6:0]  frame_addr;

    assign frame_addr = shift_reg[14:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            start_pend <= 1'b0;
            data0      <= '0;
            data1      <= '0;
            data2      <= '0;
            data3      <= '0;
            data4      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ncs_fall || start_pend) begin
                        state      <= SHIFT;
                        bit_cnt    <= '0;
                        start_pend <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Frame end wins over a coincident SCLK edge.
                    if (ncs_rise) begin
                        state <= (bit_cnt == FRAME_BITS) ? COMMIT : IDLE;
                    end else if (bit_in) begin
                        shift_reg <= {shift_reg[14:0], copi_s};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    state      <= IDLE;
                    start_pend <= ncs_fall;
                    if (shift_reg[15] && (frame_addr <= MAX_ADDR_W)) begin
                        case (frame_addr)
                            7'd0:    data0 <= shift_reg[7:0];
                            7'd1:    data1 <= shift_reg[7:0];
                            7'd2:    data2 <= shift_reg[7:0];
                            7'd3:    data3 <= shift_reg[7:0];
                            7'd4:    data4 <= shift_reg[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic        sclk_fall;
    logic [15:0] shift_next;
    logic [7:0]  rd_value;
    logic [7:0]  rb_shift;

    assign sclk_fall  = ~sclk_s & sclk_hist;
    assign shift_next = {shift_reg[14:0], copi_s};

    always_comb begin
        rd_value = 8'h00;
        if (shift_next[6:0] <= MAX_ADDR_W) begin
            case (shift_next[6:0])
                7'd0:    rd_value = data0;
                7'd1:    rd_value = data1;
                7'd2:    rd_value = data2;
                7'd3:    rd_value = data3;
                7'd4:    rd_value = data4;
                default: rd_value = 8'h00;
            endcase
        end
    end

    // Load on the 8th bit of a read frame; first shift is held until the
    // master has sampled the MSB on the 9th rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rb_shift <= '0;
        end else if ((state != SHIFT) || ncs_rise) begin
            rb_shift <= '0;
        end else if (bit_in && (bit_cnt == 5'd7) && !shift_next[7]) begin
            rb_shift <= rd_value;
        end else if (sclk_fall && (bit_cnt >= 5'd9) && (bit_cnt <= 5'd15)) begin
            rb_shift <= {rb_shift[6:0], 1'b0};
        end
    end

    assign CIPO = rb_shift[7];
`else
    assign CIPO = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_reg_bank
// Directed self-checking bench for spi_reg_bank (SCLK = clk/8, mode 0).
// Revision: 1.0
// ============================================================================
module tb_spi_reg_bank;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_ADDR    = 4;
    localparam int HALF        = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        copi;
    logic        ncs;
    logic [7:0]  data0;
    logic [7:0]  data1;
    logic [7:0]  data2;
    logic [7:0]  data3;
    logic [7:0]  data4;
    logic        cipo;
    logic [39:0] all_regs;
    logic [7:0]  rb_byte;
    logic [7:0]  rb_exp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_reg_bank #(
        .SYNC_STAGES (SYNC_STAGES),
        .MAX_ADDR    (MAX_ADDR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SCLK  (sclk),
        .COPI  (copi),
        .nCS   (ncs),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .data3 (data3),
        .data4 (data4),
        .CIPO  (cipo)
    );

    assign all_regs = {data0, data1, data2, data3, data4};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shifts the low nbits of val MSB first; CIPO is sampled before each rise.
    task automatic spi_frame(input logic [16:0] val, input int nbits, input bit end_cs);
        ncs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            copi = val[nbits-1-i];
            wait_clk(HALF);
            rb_byte = {rb_byte[6:0], cipo};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        if (end_cs) ncs = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        sclk    = 1'b0;
        copi    = 1'b0;
        ncs     = 1'b1;
        rb_byte = 8'h00;
`ifdef SPI_READBACK_EN
        rb_exp  = 8'h55;
`else
        rb_exp  = 8'h00;
`endif
        wait_clk(5);
        check("rst_data0", 64'(data0), 64'h00);
        check("rst_data1", 64'(data1), 64'h00);
        check("rst_data2", 64'(data2), 64'h00);
        check("rst_data3", 64'(data3), 64'h00);
        check("rst_data4", 64'(data4), 64'h00);
        check("rst_cipo",  64'(cipo),  64'h0);
        rst_n = 1'b1;
        wait_clk(4);

        // Write data0 and check exact latency from the nCS pin rise.
        spi_frame(17'h080F0, 16, 1'b1);
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1 check("lat_early", 64'(data0), 64'h00);
        @(posedge clk);
        #1 check("lat_data0", 64'(data0), 64'hF0);
        check("wr0_all", 64'(all_regs), 64'hF0_00_00_00_00);
        wait_clk(6);

        // Back-to-back write then read of address 4.
        spi_frame(17'h08455, 16, 1'b1);
        wait_clk(HALF);
        rb_byte = 8'h00;
        spi_frame(17'h00433, 16, 1'b1);
        wait_clk(8);
        check("wr4_data4", 64'(data4), 64'h55);
        check("rd4_all", 64'(all_regs), 64'hF0_00_00_00_55);
        check("rd4_cipo", 64'(rb_byte), 64'(rb_exp));
        check("rd4_cipo_idle", 64'(cipo), 64'h0);

        // Address above MAX_ADDR is dropped.
        spi_frame(17'h08577, 16, 1'b1);
        wait_clk(8);
        check("bad_addr", 64'(all_regs), 64'hF0_00_00_00_55);

        // 15-bit frame (0x82AA without last bit), then a 17-bit frame.
        spi_frame(17'h04155, 15, 1'b1);
        wait_clk(8);
        check("short_frame", 64'(all_regs), 64'hF0_00_00_00_55);
        spi_frame({1'b1, 16'h8199}, 17, 1'b1);
        wait_clk(8);
        check("long_frame", 64'(all_regs), 64'hF0_00_00_00_55);
        spi_frame(17'h08280, 16, 1'b1);
        wait_clk(8);
        check("wr2_all", 64'(all_regs), 64'hF0_00_80_00_55);

        spi_frame(17'h08311, 16, 1'b1);
        wait_clk(8);
        check("wr3_data3", 64'(data3), 64'h11);

        // Reset after 10 bits of 0x83C3.
        spi_frame(17'h0020F, 10, 1'b0);
        rst_n = 1'b0;
        wait_clk(5);
        ncs = 1'b1;
        wait_clk(2);
        check("midrst_all", 64'(all_regs), 64'h00_00_00_00_00);
        check("midrst_cipo", 64'(cipo), 64'h0);
        rst_n = 1'b1;
        wait_clk(8);
        check("post_rst_all", 64'(all_regs), 64'h00_00_00_00_00);
        spi_frame(17'h083C3, 16, 1'b1);
        wait_clk(8);
        check("wr3_after_rst", 64'(all_regs), 64'h00_00_00_C3_00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- SPI-slave register front end that sits directly upstream of the PWM peripheral.
- Receives 16-bit write frames on SCLK/COPI/nCS and updates five 8-bit configuration registers: output enables [7:0] and [15:8], PWM enables [7:0] and [15:8], and duty cycle.
- SPI pins are asynchronous to clk. All sampling is done with oversampled, synchronized edge detection in the clk domain; SCLK is not used as a clock.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on SCLK, COPI and nCS (minimum 2).
- MAX_ADDR, 4, highest valid register address; writes above it are dropped.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- SCLK  input  1  SPI clock, asynchronous, mode 0 (CPOL=0, CPHA=0).
- COPI  input  1  SPI data in, MSB first.
- nCS  input  1  SPI chip select, active-low.
- data0  output  8  register 0x00, output enable [7:0].
- data1  output  8  register 0x01, output enable [15:8].
- data2  output  8  register 0x02, PWM enable [7:0].
- data3  output  8  register 0x03, PWM enable [15:8].
- data4  output  8  register 0x04, PWM duty cycle.
- CIPO  output  1  SPI data out. Driven only with SPI_READBACK_EN; otherwise tied 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - data0..data4 = 0x00; CIPO = 0; bit counter = 0; shift register = 0; state = IDLE.
  - All synchronizer flops and edge-history flops reset to idle levels: SCLK 0, COPI 0, nCS 1.
- Synchronization and edge detection:
  - Each SPI pin passes through SYNC_STAGES flops.
  - One extra history flop per pin gives edge detection: sclk_rise, sclk_fall, ncs_fall, ncs_rise.
- Supported rate: SCLK high and low phases each at least 3 clk periods. Behaviour at faster rates is undefined.
- Frame format, 16 bits, MSB first:
  - bit15 = R/W (1 = write, 0 = read).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- State machine:
  - IDLE: ncs_fall -> SHIFT; bit counter cleared to 0.
  - SHIFT: on each sclk_rise with synchronized nCS low, shift synchronized COPI into the LSB of a 16-bit shift register and increment the counter. The counter saturates at 17.
  - SHIFT, ncs_rise: -> COMMIT if counter == 16; otherwise -> IDLE and the frame is discarded (short or long frame).
  - COMMIT, one cycle: if R/W = 1 and address <= MAX_ADDR, write data to the addressed register. Always -> IDLE.
- Latency: a register changes on the 2nd clk edge after ncs_rise is detected, i.e. SYNC_STAGES+2 clk edges after the nCS pin rises.
- Registers hold their value at all other times. Read frames, invalid addresses and malformed frames leave data0..data4 unchanged.
- Simultaneous events:
  - If ncs_rise and sclk_rise are detected in the same cycle, the SCLK edge is ignored (frame ended).
  - An ncs_fall arriving in COMMIT is honoured on the following IDLE cycle, so back-to-back frames need no gap beyond one synchronized nCS-high sample.
- SCLK edges while nCS is high are ignored.
- Reset mid-frame: the frame is dropped and registers return to 0x00. After reset release, the next complete frame is accepted normally.
- Address width: the full 7 bits are compared. Address 0x7F is invalid; there is no aliasing.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Enabled:
  - For a read frame (bit15 = 0), once 8 bits have been received, the addressed register value is loaded into an 8-bit output shifter. An invalid address loads 0x00.
  - CIPO presents the MSB immediately. The shifter advances on each sclk_fall for bits 9..15.
  - CIPO returns to 0 on ncs_rise and in all non-read frames.
  - Read frames never modify registers.
- Disabled: CIPO is constant 0 and no readback logic is synthesized. Register write behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n low 5 clk -> data0..data4 = 0x00, CIPO = 0.
- Write frame 0x80F0 (write, addr 0x00, data 0xF0), SCLK = clk/8 -> data0 = 0xF0 within SYNC_STAGES+2 clk of nCS rise; data1..data4 remain 0x00.
- Writes 0x8455 then 0x0433 (read, addr 0x04), back to back -> data4 = 0x55, unchanged after the read frame. With SPI_READBACK_EN, CIPO shifts out 0x55 MSB first during bits 8..15.
- Write 0x8577 (addr 0x05 > MAX_ADDR) -> all registers unchanged.
- Malformed frames: 15-bit frame 0x82AA with the last bit missing, then a 17-bit frame -> both discarded, registers unchanged. A following valid frame 0x8280 -> data2 = 0x80.
- Assert rst_n low after 10 bits of frame 0x83C3 (data3 previously written 0x11) -> data3 = 0x00, no commit. The next full frame 0x83C3 -> data3 = 0xC3.
